// File: rtl/gf_mul_16_pipe.sv
// Pipelined GF(2^16) multiplier / multiply-accumulator over GF(2^8)[z]/(z^2 + z + 0x20).
// Limb partial products are formed on entry; the tower combine and accumulation sit at the output stage.
module gf_mul_16_pipe #(
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 8,
  parameter int MAC_EN      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_x,
  input  logic [15:0]      i_y,
  input  logic             i_mode,
  input  logic             i_last,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [15:0]      o_o,
  output logic [TAG_W-1:0] o_tag
);

  // Stages ahead of the output register.
  localparam int D = PIPE_STAGES - 1;

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    // NOTE: blocking assignments are correct here; this is combinational
    // iteration inside a function, not sequential state.
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Entry partials: {x1y1, x0y1 ^ x1y0, x0y0}.
  logic [23:0] pp_in;
  assign pp_in = {gf8_mul(i_x[15:8], i_y[15:8]),
                  gf8_mul(i_x[7:0], i_y[15:8]) ^ gf8_mul(i_x[15:8], i_y[7:0]),
                  gf8_mul(i_x[7:0], i_y[7:0])};

  logic             advance;
  logic             out_v;
  logic [15:0]      out_d;
  logic [TAG_W-1:0] out_t;
  logic [15:0]      acc;

  // Whole pipeline moves together; it freezes only when the output is held.
  assign advance = !out_v || i_ready;
  assign o_ready = advance;

  logic [D-1:0]     s_v;
  logic [23:0]      s_pp   [D];
  logic [TAG_W-1:0] s_tag  [D];
  logic             s_mode [D];
  logic             s_last [D];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_v <= '0;
    end else if (advance) begin
      s_v[0] <= i_valid;
      for (int i = 1; i < D; i++) s_v[i] <= s_v[i-1];
    end
  end

  // NOTE: payload registers carry no reset; the per-stage valid bits alone
  // decide whether their contents are ever used.
  always_ff @(posedge i_clk) begin
    if (advance) begin
      s_pp[0]   <= pp_in;
      s_tag[0]  <= i_tag;
      s_mode[0] <= i_mode;
      s_last[0] <= i_last;
      for (int i = 1; i < D; i++) begin
        s_pp[i]   <= s_pp[i-1];
        s_tag[i]  <= s_tag[i-1];
        s_mode[i] <= s_mode[i-1];
        s_last[i] <= s_last[i-1];
      end
    end
  end

  logic [7:0]  hi;
  logic [7:0]  mid;
  logic [7:0]  lo;
  logic [15:0] prod;
  logic        eff_mac;

  assign {hi, mid, lo} = s_pp[D-1];
  // z^2 = z + 0x20 folds the x1y1 term into both limbs.
  assign prod    = {mid ^ hi, lo ^ gf8_mul(hi, 8'h20)};
  assign eff_mac = (MAC_EN != 0) && s_mode[D-1];

  // The pipeline is frozen while a result waits, so clearing the accumulator
  // when the last beat loads is indistinguishable from clearing at handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_v <= 1'b0;
      out_d <= '0;
      out_t <= '0;
      acc   <= '0;
    end else if (advance) begin
      out_v <= 1'b0;
      if (s_v[D-1]) begin
        if (eff_mac && !s_last[D-1]) begin
          acc <= acc ^ prod;
        end else begin
          out_v <= 1'b1;
          out_d <= eff_mac ? (acc ^ prod) : prod;
          out_t <= s_tag[D-1];
          if (eff_mac) acc <= '0;
        end
      end
    end
  end

  assign o_valid = out_v;
  assign o_o     = out_v ? out_d : 16'h0000;
  assign o_tag   = out_v ? out_t : '0;

endmodule
